// File: rtl/vga_test_pkg.sv
// Shared frame geometry and loader FSM encoding for the VGA test design.
package vga_test_pkg;

  localparam int unsigned FRAME_W     = 640;
  localparam int unsigned FRAME_H     = 480;
  localparam int unsigned FRAME_WORDS = 153600;

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    READ_LO,
    READ_HI,
    WRITE,
    RECOVER,
    DONE
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flash_image_loader_if.sv
// Flash and SRAM pin bundle driven by the boot image loader.
interface flash_image_loader_if;

  logic [21:0] flashAddr;
  logic [7:0]  flashData;
  logic        flash_oe;
  logic        flash_we;
  logic        flash_ce;
  logic        flash_rst;
  logic [17:0] sramAddr;
  logic [15:0] sramData;
  logic        sram_oe;
  logic        sram_we;
  logic        sram_ub;
  logic        sram_lb;
  logic        sram_ce;

  modport master (
    output flashAddr, flash_oe, flash_we, flash_ce, flash_rst,
    input  flashData,
    output sramAddr, sramData, sram_oe, sram_we, sram_ub, sram_lb, sram_ce
  );

  modport slave (
    input  flashAddr, flash_oe, flash_we, flash_ce, flash_rst,
    output flashData,
    input  sramAddr, sramData, sram_oe, sram_we, sram_ub, sram_lb, sram_ce
  );

endinterface

// File: rtl/flash_image_loader.sv
// Boot copy engine: pulses flash reset, packs flash byte pairs into SRAM words, then raises ready.
// Optional macro CHECKSUM_EN adds a 16-bit running sum of every latched flash byte.
module flash_image_loader
  import vga_test_pkg::*;
#(
  parameter int unsigned WORDS      = FRAME_WORDS,
  parameter int unsigned FLASH_BASE = 0,
  parameter int unsigned SRAM_BASE  = 0,
  parameter int unsigned FLASH_WAIT = 3,
  parameter int unsigned WE_CYCLES  = 1,
  parameter int unsigned RST_CYCLES = 13
) (
  input  logic                 clk,
  input  logic                 n_reset,
  flash_image_loader_if.master bus,
`ifdef CHECKSUM_EN
  output logic [15:0]          checksum,
`endif
  output logic                 ready
);

  localparam int unsigned CNT_MAX = max3(FLASH_WAIT, WE_CYCLES, RST_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned IDX_W   = 18;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FLASH_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORDS - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [7:0]       r_data_lo, r_data_hi;
  logic             w_latch_lo, w_latch_hi;
  logic [21:0]      r_flash_addr, w_flash_addr_next;
  logic [17:0]      r_sram_addr, w_sram_addr_next;
  logic             r_ready, r_flash_rst, r_flash_en_n, r_sram_we_n;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    w_latch_lo   = 1'b0;
    w_latch_hi   = 1'b0;
    unique case (r_state)
      RST_HOLD: if (r_cnt == RST_LAST) begin
        w_state_next = RST_WAIT;
        w_cnt_next   = '0;
      end
      RST_WAIT: if (r_cnt == RST_LAST) begin
        w_state_next = READ_LO;
        w_cnt_next   = '0;
      end
      READ_LO: if (r_cnt == WAIT_LAST) begin
        w_latch_lo   = 1'b1;
        w_state_next = READ_HI;
        w_cnt_next   = '0;
      end
      READ_HI: if (r_cnt == WAIT_LAST) begin
        w_latch_hi   = 1'b1;
        w_state_next = WRITE;
        w_cnt_next   = '0;
      end
      WRITE: if (r_cnt == WE_LAST) begin
        w_state_next = RECOVER;
        w_cnt_next   = '0;
      end
      RECOVER: begin
        w_cnt_next = '0;
        if (r_idx == IDX_LAST) begin
          w_state_next = DONE;
        end else begin
          w_idx_next   = r_idx + IDX_W'(1);
          w_state_next = READ_LO;
        end
      end
      DONE: w_cnt_next = '0;
      default: begin
        w_state_next = RST_HOLD;
        w_cnt_next   = '0;
      end
    endcase

    // SRAM address is driven from READ_LO onward so it is settled well before the write strobe.
    w_flash_addr_next = 22'(FLASH_BASE) + {3'b000, w_idx_next, (w_state_next == READ_HI)};
    w_sram_addr_next  = IDX_W'(SRAM_BASE) + w_idx_next;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state      <= RST_HOLD;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_data_lo    <= '0;
      r_data_hi    <= '0;
      r_flash_addr <= 22'(FLASH_BASE);
      r_sram_addr  <= IDX_W'(SRAM_BASE);
      r_ready      <= 1'b0;
      r_flash_rst  <= 1'b0;
      r_flash_en_n <= 1'b1;
      r_sram_we_n  <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      if (w_latch_lo) r_data_lo <= bus.flashData;
      if (w_latch_hi) r_data_hi <= bus.flashData;
      r_flash_addr <= w_flash_addr_next;
      r_sram_addr  <= w_sram_addr_next;
      r_ready      <= (w_state_next == DONE);
      r_flash_rst  <= (w_state_next != RST_HOLD);
      r_flash_en_n <= !(w_state_next inside {READ_LO, READ_HI, WRITE, RECOVER});
      r_sram_we_n  <= (w_state_next != WRITE);
    end
  end

`ifdef CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_checksum <= '0;
    end else if (w_latch_lo || w_latch_hi) begin
      r_checksum <= r_checksum + {8'h00, bus.flashData};
    end
  end

  assign checksum = r_checksum;
`endif

  assign bus.flashAddr = r_flash_addr;
  assign bus.flash_oe  = r_flash_en_n;
  assign bus.flash_ce  = r_flash_en_n;
  assign bus.flash_we  = 1'b1;
  assign bus.flash_rst = r_flash_rst;
  assign bus.sramAddr  = r_sram_addr;
  // Even flash byte lands in [7:0], odd byte in [15:8].
  assign bus.sramData  = {r_data_hi, r_data_lo};
  assign bus.sram_oe   = 1'b1;
  assign bus.sram_we   = r_sram_we_n;
  assign bus.sram_ub   = r_sram_we_n;
  assign bus.sram_lb   = r_sram_we_n;
  assign bus.sram_ce   = 1'b0;
  assign ready         = r_ready;

endmodule
